// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - memory op codes, load-extension codes and FSM encoding shared by the MEM stage
package mem_access_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        RAM_EXT_B  = 3'd0,
        RAM_EXT_BU = 3'd1,
        RAM_EXT_H  = 3'd2,
        RAM_EXT_HU = 3'd3,
        RAM_EXT_W  = 3'd4
    } ram_ext_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

    function automatic logic [2:0] op_ext(input logic [3:0] op);
        logic [2:0] ext;
        case (op)
            MEM_OP_LB:  ext = RAM_EXT_B;
            MEM_OP_LBU: ext = RAM_EXT_BU;
            MEM_OP_LH:  ext = RAM_EXT_H;
            MEM_OP_LHU: ext = RAM_EXT_HU;
            default:    ext = RAM_EXT_W;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_st_align.sv
// rtl/mem_access_ctrl_st_align.sv - store byte strobes and lane-replicated write data from op and byte offset
module mem_access_ctrl_st_align (
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_rep
);
    import mem_access_ctrl_pkg::*;

    // Data is replicated across all lanes so the strobes alone pick the target bytes.
    always_comb begin
        we        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (op)
            MEM_OP_SB: begin
                we        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_OP_SH: begin
                we        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
            end
            MEM_OP_SW: begin
                we        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                we        = 4'b0000;
                wdata_rep = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage req/gnt/rvalid data-bus master feeding the load extender
// Optional bus watchdog enabled by defining DBUS_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dbus_req,
    output logic [3:0]  dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        resp_valid,
    output logic [31:0] ld_word,
    output logic [1:0]  ld_offset,
    output logic [2:0]  ld_ext_op,
    output logic        ale,
    output logic        bus_err,
    output logic        busy
);
    import mem_access_ctrl_pkg::*;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_word_q, ld_word_d;
    logic [2:0]  ext_q, ext_d;
    logic        ale_q, ale_d;
    logic        bus_err_q, bus_err_d;
    logic        accept;
    logic        expired;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q holds the cycles already spent, so this cycle is number TIMEOUT_CYCLES.
    assign expired = ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ld_word_d = ld_word_q;
        ext_d     = ext_q;
        ale_d     = ale_q;
        bus_err_d = bus_err_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && (op_is_load(req_op) || op_is_store(req_op))) begin
                    accept    = 1'b1;
                    op_d      = req_op;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    ext_d     = op_ext(req_op);
                    ld_word_d = 32'h0000_0000;
                    bus_err_d = 1'b0;
                    ale_d     = op_misaligned(req_op, req_addr[1:0]);
                    state_d   = ale_d ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // A grant in the expiry cycle takes priority over the watchdog.
                if (dbus_gnt) begin
                    state_d = op_is_store(op_q) ? ST_DONE : ST_WAIT;
                end else if (expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (dbus_rvalid) begin
                    ld_word_d = dbus_rdata;
                    state_d   = ST_DONE;
                end else if (expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'h0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            ld_word_q <= 32'h0000_0000;
            ext_q     <= 3'd0;
            ale_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ld_word_q <= ld_word_d;
            ext_q     <= ext_d;
            ale_q     <= ale_d;
            bus_err_q <= bus_err_d;
        end
    end

    mem_access_ctrl_st_align u_st_align (
        .op        (op_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .we        (st_we),
        .wdata_rep (st_wdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = ~req_ready;
    assign dbus_req   = (state_q == ST_REQ);
    assign dbus_we    = dbus_req ? st_we : 4'b0000;
    assign dbus_addr  = {addr_q[31:2], 2'b00};
    assign dbus_wdata = st_wdata;
    assign resp_valid = (state_q == ST_DONE);
    assign ld_word    = ld_word_q;
    assign ld_offset  = addr_q[1:0];
    assign ld_ext_op  = ext_q;
    assign ale        = ale_q;
    assign bus_err    = bus_err_q;

endmodule
